// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: memctrl byte-read port, EX redirect and the decode handshake.
// master = inst_fetch side, slave = the memctrl/EX/decode side.
interface inst_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              mc_req;
    logic [ADDR_W-1:0] mc_addr;
    logic              mc_grant;
    logic [7:0]        mc_data;
    logic              jump_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] pc_o;

    modport master (
        output mc_req, mc_addr, inst_valid_o, inst_o, pc_o,
        input  mc_grant, mc_data, jump_i, jump_addr_i, inst_ready_i
    );

    modport slave (
        input  mc_req, mc_addr, inst_valid_o, inst_o, pc_o,
        output mc_grant, mc_data, jump_i, jump_addr_i, inst_ready_i
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: gathers four little-endian bytes over the shared byte-wide
// RAM port, survives lost arbitration cycles, and hands {pc, inst} to decode.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        issue_cnt;
    logic [1:0]        recv_cnt;
    logic              pend;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] pc_q;
    logic              valid_q;
    logic              mc_req_c;
    logic [ADDR_W-1:0] mc_addr_c;

    // Request while bytes remain to issue; a redirect cycle never requests.
    always_comb begin
        mc_req_c  = (state == S_FETCH) && (issue_cnt < 3'd4) && !bus.jump_i;
        mc_addr_c = '0;
        if (mc_req_c) begin
            mc_addr_c = pc + ADDR_W'(issue_cnt);
        end
    end

    assign bus.mc_req       = mc_req_c;
    assign bus.mc_addr      = mc_addr_c;
    assign bus.inst_valid_o = valid_q;
    assign bus.inst_o       = inst_q;
    assign bus.pc_o         = pc_q;

    // Fetch sequencing; reset beats redirect, redirect beats everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pend      <= 1'b0;
            inst_q    <= '0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
        end else if (bus.jump_i) begin
            // Clearing pend here drops any byte still returning from a pre-redirect grant.
            state     <= S_FETCH;
            pc        <= bus.jump_addr_i & ALIGN_MASK;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pend      <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    pend <= mc_req_c && bus.mc_grant;
                    if (mc_req_c && bus.mc_grant) begin
                        issue_cnt <= issue_cnt + 3'd1;
                    end
                    if (pend) begin
                        inst_q[{recv_cnt, 3'b000} +: 8] <= bus.mc_data;
                        recv_cnt <= recv_cnt + 2'd1;
                        if (recv_cnt == 2'd3) begin
                            state   <= S_VALID;
                            valid_q <= 1'b1;
                            pc_q    <= pc;
                        end
                    end
                end
                S_VALID: begin
                    if (bus.inst_ready_i) begin
                        state     <= S_FETCH;
                        valid_q   <= 1'b0;
                        pc        <= pc + WORD_STEP;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        pend      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
